// File: rtl/dmem_responder.sv
// Data-memory responder: 64-bit storage serving one load/store at a time over
// valid/ready, answering a fixed LATENCY cycles after the request is accepted.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          err_reg;
  logic          accept, addr_err, do_read, do_write;
  logic [63:0]   offset, word_off;
  logic [AW-1:0] idx;

  assign accept   = req_valid & req_ready;
  // Range check at full width so addresses far outside the window never alias.
  assign offset   = req_addr - BASE_ADDR;
  assign word_off = offset >> 3;
  assign addr_err = (req_addr < BASE_ADDR) | (word_off >= 64'(DEPTH_WORDS));
  assign idx      = word_off[AW-1:0];
  assign do_read  = req_ren & ~addr_err;
  assign do_write = accept & req_wen & ~addr_err;

  // One byte-lane RAM per mask bit; the read register captures the pre-write value.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (do_write && req_wmask[gi]) begin
          lane_mem[idx] <= req_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_q <= 8'h00;
        end else if (accept) begin
          lane_q <= do_read ? lane_mem[idx] : 8'h00;
        end
      end

      assign resp_rdata[8*gi +: 8] = lane_q;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        err_reg <= addr_err;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = err_reg;

endmodule
